// File: rtl/stopwatch_sequencer.sv
// ============================================================================
// Module      : stopwatch_sequencer
// Description : Run/pause/lap/clear controller that drives a chain of cascaded
//               BCD decade digits from a programmable tick prescaler.
//               Optional macro STOPWATCH_TC_STOP_EN: saturate and pause at
//               terminal count instead of wrapping to zero.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module stopwatch_sequencer #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  running,
    output logic                  lap_active,
    output logic                  tc
);

    localparam int              C_PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [C_PW-1:0] C_TICK_LAST = C_PW'(TICK_DIV - 1);
    localparam logic [C_PW-1:0] C_PRESC_ONE = C_PW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t                r_state;
    logic [C_PW-1:0]       r_presc;
    logic [4*DIGITS-1:0]   r_digits;
    logic [4*DIGITS-1:0]   r_snap;
    logic                  r_running;
    logic                  r_lap_active;
    logic                  r_tc;

    state_t                w_state_nxt;
    logic [C_PW-1:0]       w_presc_nxt;
    logic [4*DIGITS-1:0]   w_digits_nxt;
    logic [4*DIGITS-1:0]   w_snap_nxt;
    logic [4*DIGITS-1:0]   w_digits_inc;
    logic                  w_all9;
    logic                  w_counting;
    logic                  w_tick;
    logic                  w_tc_hit;
    logic                  w_ev_ss;
    logic                  w_ev_clr;
    logic                  w_ev_lap;
    logic                  w_sat;

`ifdef STOPWATCH_TC_STOP_EN
    logic                  r_sat;
    logic                  w_sat_nxt;
    assign w_sat = r_sat;
`else
    assign w_sat = 1'b0;
`endif

    // Single event per cycle: the highest-priority pulse wins, the rest drop.
    assign w_ev_ss  = start_stop;
    assign w_ev_clr = clear & ~start_stop;
    assign w_ev_lap = lap & ~start_stop & ~clear;

    assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick     = w_counting && (r_presc == C_TICK_LAST);
    assign w_tc_hit   = w_tick && w_all9;

    // Ripple carry through the decades; out-of-range codes recover to 0.
    always_comb begin
        w_all9       = 1'b1;
        w_digits_inc = r_digits;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_all9) begin
                w_digits_inc[4*i +: 4] = (r_digits[4*i +: 4] >= 4'd9) ?
                                         4'd0 : r_digits[4*i +: 4] + 4'd1;
            end
            w_all9 = w_all9 & (r_digits[4*i +: 4] == 4'd9);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = r_presc;
        w_digits_nxt = r_digits;
        w_snap_nxt   = r_snap;
`ifdef STOPWATCH_TC_STOP_EN
        w_sat_nxt    = r_sat;
`endif

        if (w_counting) begin
            w_presc_nxt = w_tick ? '0 : r_presc + C_PRESC_ONE;
        end
        if (w_tick) begin
            w_digits_nxt = w_digits_inc;
        end

        case (r_state)
            S_IDLE: begin
                if (w_ev_ss) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_ev_ss) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_ev_lap) begin
                    w_state_nxt = S_LAP;
                    w_snap_nxt  = r_digits;
                end
            end
            S_LAP: begin
                if (w_ev_ss) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_ev_lap) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_PAUSE: begin
                if (w_ev_ss && !w_sat) begin
                    w_state_nxt = S_RUN;
                end else if (w_ev_clr) begin
                    w_state_nxt  = S_IDLE;
                    w_digits_nxt = '0;
                    w_presc_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

`ifdef STOPWATCH_TC_STOP_EN
        // Terminal count overrides any same-cycle event: hold at all 9s, stop.
        if (w_tc_hit) begin
            w_digits_nxt = r_digits;
            w_state_nxt  = S_PAUSE;
            w_sat_nxt    = 1'b1;
        end
        if (w_state_nxt == S_IDLE) begin
            w_sat_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_presc      <= '0;
            r_digits     <= '0;
            r_snap       <= '0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_tc         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_digits     <= w_digits_nxt;
            r_snap       <= w_snap_nxt;
            r_running    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
            r_lap_active <= (w_state_nxt == S_LAP);
            r_tc         <= w_tc_hit;
        end
    end

`ifdef STOPWATCH_TC_STOP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat <= 1'b0;
        end else begin
            r_sat <= w_sat_nxt;
        end
    end
`endif

    assign disp       = (r_state == S_LAP) ? r_snap : r_digits;
    assign running    = r_running;
    assign lap_active = r_lap_active;
    assign tc         = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_sequencer.sv
// ============================================================================
// Module      : tb_stopwatch_sequencer
// Description : Self-checking bench for stopwatch_sequencer (DIGITS=2,
//               TICK_DIV=4); honours STOPWATCH_TC_STOP_EN when defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ss  = 1'b0;
    logic       clr = 1'b0;
    logic       lp  = 1'b0;
    logic [7:0] disp;
    logic       running;
    logic       lap_active;
    logic       tc;

    stopwatch_sequencer #(
        .DIGITS   (2),
        .TICK_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (ss),
        .clear      (clr),
        .lap        (lp),
        .disp       (disp),
        .running    (running),
        .lap_active (lap_active),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ss;
        logic       clr;
        logic       lp;
        int         cyc;
        logic [7:0] disp;
        logic       run;
        logic       lapa;
        logic       tc;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] disp;
        logic       run;
        logic       lapa;
        logic       tc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void addv(input logic a, input logic b, input logic c, input int cyc,
                                 input logic [7:0] d, input logic r, input logic l, input logic t);
        vec_t v;
        v.ss = a; v.clr = b; v.lp = c; v.cyc = cyc;
        v.disp = d; v.run = r; v.lapa = l; v.tc = t;
        vecs.push_back(v);
    endfunction

    task automatic expect_out(input string name, input logic [7:0] d, input logic r,
                              input logic l, input logic t);
        exp_t e;
        e.name = name; e.disp = d; e.run = r; e.lapa = l; e.tc = t;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".disp"}, disp, e.disp);
            chk({e.name, ".running"}, running, e.run);
            chk({e.name, ".lap_active"}, lap_active, e.lapa);
            chk({e.name, ".tc"}, tc, e.tc);
        end
    endtask

    task automatic step(input logic a, input logic b, input logic c, input int cyc);
        ss = a; clr = b; lp = c;
        @(posedge clk); #1;
        ss = 1'b0; clr = 1'b0; lp = 1'b0;
        for (int k = 1; k < cyc; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Stimulus table: ss, clr, lap, edges, expected disp/running/lap_active/tc
        addv(1,0,0,  1, 8'h00, 1,0,0);   // IDLE -> RUN
        addv(0,0,0,  3, 8'h00, 1,0,0);
        addv(0,0,0,  1, 8'h01, 1,0,0);   // first increment 4 edges after start
        addv(0,0,0, 36, 8'h10, 1,0,0);
        addv(1,0,0,  1, 8'h10, 0,0,0);   // pause
        addv(0,1,0,  1, 8'h00, 0,0,0);   // clear -> IDLE
        addv(0,0,1,  1, 8'h00, 0,0,0);   // lap ignored in IDLE
        addv(0,1,0,  1, 8'h00, 0,0,0);   // clear ignored in IDLE
        addv(1,0,0,  6, 8'h01, 1,0,0);   // start, prescaler at 1
        addv(1,0,0, 11, 8'h01, 0,0,0);   // pause at prescaler 2, hold 10
        addv(1,0,0,  1, 8'h01, 1,0,0);   // resume
        addv(0,0,0,  1, 8'h01, 1,0,0);
        addv(0,0,0,  1, 8'h02, 1,0,0);   // increment 2 edges after resume
        addv(0,0,0, 84, 8'h23, 1,0,0);
        addv(0,0,1,  1, 8'h23, 1,1,0);   // lap freeze
        addv(0,0,0, 11, 8'h23, 1,1,0);   // live count advances 3 ticks
        addv(0,0,1,  1, 8'h26, 1,0,0);   // unfreeze
        addv(0,1,0,  1, 8'h26, 1,0,0);   // clear ignored in RUN
        addv(1,1,1,  1, 8'h26, 0,0,0);   // all three: pause only
        addv(0,0,1,  1, 8'h26, 0,0,0);   // lap ignored in PAUSE
        addv(1,0,0,  1, 8'h26, 1,0,0);
        addv(0,0,0,  1, 8'h27, 1,0,0);
        addv(0,0,0,  3, 8'h27, 1,0,0);
        addv(0,0,1,  1, 8'h27, 1,1,0);   // lap on tick: pre-increment snapshot
        addv(1,0,0,  1, 8'h28, 0,0,0);   // LAP -> PAUSE shows live
        addv(1,0,0,  1, 8'h28, 1,0,0);
        addv(0,0,0,  2, 8'h28, 1,0,0);
        addv(1,0,0,  1, 8'h29, 0,0,0);   // start_stop on tick: increment kept
        addv(1,0,0,  1, 8'h29, 1,0,0);
        addv(0,0,0,283, 8'h99, 1,0,0);
`ifdef STOPWATCH_TC_STOP_EN
        addv(0,0,0,  1, 8'h99, 0,0,1);   // saturate and pause
        addv(0,0,0,  1, 8'h99, 0,0,0);
        addv(1,0,0,  1, 8'h99, 0,0,0);   // start_stop ignored at saturation
`else
        addv(0,0,0,  1, 8'h00, 1,0,1);   // wrap to zero
        addv(0,0,0,  1, 8'h00, 1,0,0);
        addv(1,0,0,  1, 8'h00, 0,0,0);
`endif
        addv(0,1,0,  1, 8'h00, 0,0,0);   // clear -> IDLE
        addv(1,0,0,  5, 8'h01, 1,0,0);   // prescaler was zeroed by clear

        repeat (3) @(posedge clk);
        #1;
        expect_out("in_reset", 8'h00, 0, 0, 0);
        compare_out();
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            expect_out($sformatf("idle%0d", c), 8'h00, 0, 0, 0);
            compare_out();
        end

        foreach (vecs[i]) begin
            expect_out($sformatf("vec%0d", i), vecs[i].disp, vecs[i].run, vecs[i].lapa, vecs[i].tc);
            step(vecs[i].ss, vecs[i].clr, vecs[i].lp, vecs[i].cyc);
            compare_out();
        end

        // Reset asserted mid-LAP clears outputs before the next clock edge
        expect_out("lap_before_rst", 8'h01, 1, 1, 0);
        step(1'b0, 1'b0, 1'b1, 5);
        compare_out();
        #2;
        rst = 1'b0;
        #1;
        expect_out("async_rst", 8'h00, 0, 0, 0);
        compare_out();
        ss = 1'b1;
        @(posedge clk); #1;
        ss = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            expect_out($sformatf("post_rst%0d", c), 8'h00, 0, 0, 0);
            compare_out();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stopwatch_sequencer.md
Name: stopwatch_sequencer

Overview:
- Run/pause/lap/clear controller that sequences a chain of cascaded 8421 BCD decade digits from a programmable tick prescaler.
- Sits between debounced front-panel pulses and the 7-segment display driver.
- Owns the digit counters, the prescaler and the lap snapshot register.

Parameters:
- DIGITS, 4, number of cascaded BCD decade digits (1..8).
- TICK_DIV, 100000, clk cycles per count increment (>=2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start_stop  input  1  single-cycle pulse; toggles run/pause.
- clear  input  1  single-cycle pulse; zeroes count when paused.
- lap  input  1  single-cycle pulse; freezes/unfreezes display while counting.
- disp  output  4*DIGITS  BCD digits for display; digit 0 in [3:0].
- running  output  1  high in RUN and LAP.
- lap_active  output  1  high in LAP.
- tc  output  1  one-cycle pulse on terminal count (all digits 9 and tick).

Behaviour:
- Reset (rst=0, async): state=IDLE, all digits 0, prescaler 0, snapshot 0, disp=0, running=0, lap_active=0, tc=0.
- States: IDLE, RUN, LAP, PAUSE. Pulses are sampled on rising clk. At most one event acts per cycle, with priority start_stop > clear > lap. Lower-priority pulses in the same cycle are dropped.
- IDLE: start_stop -> RUN. clear and lap are ignored.
- RUN: start_stop -> PAUSE. lap -> LAP; the snapshot loads the pre-edge count. clear is ignored.
- LAP: counting continues while disp shows the snapshot. lap -> RUN (disp live). start_stop -> PAUSE (disp live). clear is ignored.
- PAUSE: start_stop -> RUN. clear -> IDLE (digits and prescaler zeroed on that edge). lap is ignored.
- running and lap_active are registered and change on the same edge as the state.
- Prescaler:
  - counts 0..TICK_DIV-1 only in RUN/LAP; holds in PAUSE; zero in IDLE.
  - tick = (prescaler==TICK_DIV-1) while in RUN/LAP; the prescaler wraps to 0 on tick.
  - First increment after IDLE->RUN lands exactly TICK_DIV edges after the start edge.
  - PAUSE/RUN preserves the partial prescaler count, so no time is lost.
- Digit chain:
  - on tick, digit i increments iff all lower digits ==9.
  - a digit at 9 that increments wraps to 0; each digit stays in 0..9.
  - Digit values 10..15 are unreachable. If forced, the digit returns to 0 on its next increment.
- Terminal count (all digits 9 and tick): all digits -> 0, tc=1 for exactly one cycle (the next cycle), state unchanged.
- tick coinciding with start_stop in RUN: the increment is applied and the state goes to PAUSE.
- tick coinciding with lap: the snapshot takes the pre-increment value.
- disp: snapshot in LAP, otherwise the live digits. disp is registered-equivalent, with no combinational path from inputs.
- Reset mid-run: immediate return to the reset values above. No pending event survives reset.

Optional Feature:
- Macro: STOPWATCH_TC_STOP_EN.
- Defined: at terminal count, digits saturate at all 9s instead of wrapping, tc pulses once, and the state is forced to PAUSE (from LAP, disp becomes live). start_stop from PAUSE at saturation is ignored; only clear exits.
- Undefined: wrap-to-zero behaviour as specified above.

Test Plan:
- Bench parameters: DIGITS=2, TICK_DIV=4.
- Reset then idle: release rst, no pulses for 20 cycles -> disp=8'h00, running=0, tc=0 throughout.
- Basic count: start_stop at cycle 0, run 40 cycles -> running=1 from cycle 1; disp=8'h01 after edge 4, 8'h10 after edge 40.
- Pause/resume preserves the prescaler:
  - start at 0; start_stop at cycle 6 (prescaler=2, disp=01); wait 10 cycles -> disp stays 01.
  - start_stop again -> next increment 2 edges later, disp=02.
- Lap freeze:
  - in RUN at disp=8'h23, lap pulse -> lap_active=1, disp holds 23 while the live count advances 3 ticks.
  - second lap -> disp=8'h26, lap_active=0.
- Terminal count: run to 99, next tick -> disp=8'h00, tc high for exactly 1 cycle. With STOPWATCH_TC_STOP_EN: disp=8'h99, running=0, a later start_stop is ignored, clear -> disp=00 and state IDLE.
- Simultaneous and illegal events:
  - start_stop+clear+lap in the same cycle while in RUN -> PAUSE only, digits kept.
  - clear in RUN ignored.
  - rst asserted mid-LAP -> all outputs 0 asynchronously, before the next clk edge.
